// File: rtl/seg_scan_ctrl.sv
// Scan controller for a multiplexed 7-segment display: steps one digit per CLK_DIV clocks
// and double-buffers the display word. Optional blinking is built when SEG_BLINK_EN is defined.
module seg_scan_ctrl #(
    parameter int CLK_DIV      = 100000,
    parameter int DIGITS       = 8,
    parameter int BLINK_FRAMES = 125
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [31:0]       data_in,
    input  logic              load,
    input  logic              lz_en,
    input  logic [DIGITS-1:0] blink_mask,
    output logic [2:0]        an_sel,
    output logic [3:0]        hex_digit,
    output logic              digit_on,
    output logic              busy
);

    localparam int             DW       = $clog2(CLK_DIV);
    localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [2:0]     IDX_LAST = 3'(DIGITS - 1);

    logic [DW-1:0] div_cnt;
    logic [2:0]    idx;
    logic [31:0]   disp;
    logic [31:0]   pend;
    logic          pend_v;
    logic          tick;
    logic          frame_end;
    logic          lz_blank;
    logic          blink_off;

    assign tick      = (div_cnt == DIV_LAST);
    assign frame_end = tick && (idx == IDX_LAST);

    // load is a one-cycle strobe with no back-pressure; busy reports a word waiting for the
    // next frame boundary, and a load while busy replaces that word.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_cnt <= '0;
            idx     <= '0;
            disp    <= '0;
            pend    <= '0;
            pend_v  <= 1'b0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick)
                idx <= (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
            if (load)
                pend <= data_in;
            if (load)
                pend_v <= 1'b1;
            else if (frame_end)
                pend_v <= 1'b0;
            // Commit uses the old pending word even when a new load lands on the same edge.
            if (frame_end && pend_v)
                disp <= pend;
        end
    end

    // A digit is a leading zero when it and every more significant scanned nibble are zero.
    always_comb begin
        lz_blank = lz_en && (idx != 3'd0);
        for (int i = 0; i < DIGITS; i++) begin
            if ((3'(i) >= idx) && (disp[4*i +: 4] != 4'd0))
                lz_blank = 1'b0;
        end
    end

`ifdef SEG_BLINK_EN
    localparam int            FW      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FW-1:0] FC_LAST = FW'(BLINK_FRAMES - 1);

    logic [FW-1:0] frame_cnt;
    logic          phase;
    logic [7:0]    mask8;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            frame_cnt <= '0;
            phase     <= 1'b0;
        end else if (frame_end) begin
            if (frame_cnt == FC_LAST) begin
                frame_cnt <= '0;
                phase     <= ~phase;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    assign mask8     = 8'(blink_mask);
    assign blink_off = phase & mask8[idx];
`else
    localparam int unused_blink_frames = BLINK_FRAMES;
    logic          unused_blink_mask;

    assign unused_blink_mask = ^blink_mask;
    assign blink_off         = 1'b0;
`endif

    assign an_sel    = idx;
    assign hex_digit = disp[{idx, 2'b00} +: 4];
    assign digit_on  = ~lz_blank & ~blink_off;
    assign busy      = pend_v;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl (CLK_DIV=4, DIGITS=8, BLINK_FRAMES=2): the driver queues
// hand-computed per-slot outputs, a negedge monitor compares them at their scheduled cycle.
module tb_seg_scan_ctrl;

    localparam int W = 9;

`ifdef SEG_BLINK_EN
    localparam logic [7:0] BLINK_ON = 8'hFE;
`else
    localparam logic [7:0] BLINK_ON = 8'hFF;
`endif

    localparam logic [W-1:0] RST_EXP = {3'd0, 4'd0, 1'b1, 1'b0};

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] data_in;
    logic        load;
    logic        lz_en;
    logic [7:0]  blink_mask;
    logic [2:0]  an_sel;
    logic [3:0]  hex_digit;
    logic        digit_on;
    logic        busy;

    logic [W-1:0] exp_q[$];
    int           exp_cyc_q[$];
    int           exp_tag_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = -1;

    seg_scan_ctrl #(
        .CLK_DIV     (4),
        .DIGITS      (8),
        .BLINK_FRAMES(2)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .data_in   (data_in),
        .load      (load),
        .lz_en     (lz_en),
        .blink_mask(blink_mask),
        .an_sel    (an_sel),
        .hex_digit (hex_digit),
        .digit_on  (digit_on),
        .busy      (busy)
    );

    // ---------------- clock / reset-relative cycle counter ----------------
    always #5 clk = ~clk;

    // cyc = number of rising edges since reset release; -1 while reset is held.
    always @(posedge clk or negedge rstn) begin
        if (!rstn)
            cyc <= -1;
        else
            cyc <= (cyc < 0) ? 1 : cyc + 1;
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [W-1:0] got;
        got = {an_sel, hex_digit, digit_on, busy};
        if (exp_q.size() > 0) begin
            if (exp_cyc_q[0] == cyc) begin
                n_checks++;
                if (got == exp_q[0])
                    n_pass++;
                else
                    $display("FAIL slot tag=%0d cyc=%0d: got an=%0d hex=%h on=%b busy=%b, expected an=%0d hex=%h on=%b busy=%b",
                             exp_tag_q[0], cyc, got[8:6], got[5:2], got[1], got[0],
                             exp_q[0][8:6], exp_q[0][5:2], exp_q[0][1], exp_q[0][0]);
                void'(exp_q.pop_front());
                void'(exp_cyc_q.pop_front());
                void'(exp_tag_q.pop_front());
            end else if (exp_cyc_q[0] >= 0 && cyc > exp_cyc_q[0]) begin
                n_checks++;
                $display("FAIL missed tag=%0d: sample cycle %0d passed (now %0d), expected %h",
                         exp_tag_q[0], exp_cyc_q[0], cyc, exp_q[0]);
                void'(exp_q.pop_front());
                void'(exp_cyc_q.pop_front());
                void'(exp_tag_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push(input int c, input logic [W-1:0] v, input int tag);
        exp_q.push_back(v);
        exp_cyc_q.push_back(c);
        exp_tag_q.push_back(tag);
    endtask

    // Expected slots of frame f: word w shown, on/busy masks indexed by digit.
    task automatic frame(input int f, input logic [31:0] w, input logic [7:0] on,
                         input logic [7:0] bz, input int n, input int lbl);
        for (int i = 0; i < n; i++)
            push(32*f + 4*i + 2, {3'(i), w[4*i +: 4], on[i], bz[i]}, lbl*8 + i);
    endtask

    task automatic wait_cyc(input int n);
        int guard;
        guard = 0;
        while (cyc != n && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != n) begin
            n_checks++;
            $display("FAIL wait_cyc: cycle counter at %0d, required %0d", cyc, n);
        end
    endtask

    task automatic pulse_load(input int n, input logic [31:0] d);
        wait_cyc(n);
        data_in = d;
        load    = 1'b1;
        wait_cyc(n + 1);
        load    = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rstn       = 1'b0;
        load       = 1'b0;
        data_in    = 32'h0;
        lz_en      = 1'b0;
        blink_mask = 8'h00;
        push(-1, RST_EXP, 999);
        repeat (3) @(negedge clk);
        #1 rstn = 1'b1;

        frame(0, 32'h0000_0000, 8'hFF, 8'h00, 8, 0);
        frame(1, 32'h0000_0000, 8'hFF, 8'hF8, 8, 1);
        pulse_load(44, 32'h1234_ABCD);

        frame(2, 32'h1234_ABCD, 8'hFF, 8'h00, 8, 2);
        frame(3, 32'h1234_ABCD, 8'hFF, 8'hFE, 8, 3);
        pulse_load(100, 32'h1111_1111);
        pulse_load(108, 32'h2222_2222);
        pulse_load(127, 32'h3333_3333);

        frame(4, 32'h2222_2222, 8'hFF, 8'hFF, 8, 4);
        frame(5, 32'h3333_3333, 8'hFF, 8'hFE, 8, 5);
        pulse_load(164, 32'h0000_0050);

        frame(6, 32'h0000_0050, 8'h03, 8'h00, 8, 6);
        wait_cyc(192);
        lz_en = 1'b1;

        frame(7, 32'h0000_0050, 8'hFF, 8'hFE, 8, 7);
        wait_cyc(224);
        lz_en = 1'b0;
        pulse_load(228, 32'h0000_0000);

        frame(8, 32'h0000_0000, 8'h01, 8'h00, 8, 8);
        wait_cyc(256);
        lz_en = 1'b1;

        frame(9,  32'h0000_0000, 8'hFF,    8'h00, 8, 9);
        frame(10, 32'h0000_0000, BLINK_ON, 8'h00, 8, 10);
        frame(11, 32'h0000_0000, BLINK_ON, 8'h00, 8, 11);
        frame(12, 32'h0000_0000, 8'hFF,    8'h00, 8, 12);
        wait_cyc(288);
        lz_en      = 1'b0;
        blink_mask = 8'h01;

        frame(13, 32'h0000_0000, 8'hFF, 8'hFE, 3, 13);
        wait_cyc(416);
        blink_mask = 8'h00;
        pulse_load(420, 32'hDEAD_BEEF);
        wait_cyc(426);
        push(-1, RST_EXP, 998);
        #1 rstn = 1'b0;
        repeat (2) @(negedge clk);
        #1 rstn = 1'b1;

        frame(0, 32'h0000_0000, 8'hFF, 8'h00, 8, 14);
        frame(1, 32'h0000_0000, 8'hFF, 8'h00, 1, 15);

        for (int k = 0; k < 200 && exp_q.size() > 0; k++)
            @(negedge clk);
        while (exp_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain tag=%0d: never sampled, expected %h", exp_tag_q[0], exp_q[0]);
            void'(exp_q.pop_front());
            void'(exp_cyc_q.pop_front());
            void'(exp_tag_q.pop_front());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
